cpu_clint: RTL and testbench
============================

# cpu_clint

Machine-mode timer and interrupt source block that sits directly upstream of `cpu_csr` and drives its MIP bits. It provides a memory-mapped 64-bit `mtime` counter and `mtimecmp` compare register, a software-interrupt bit, and an edge-latched external interrupt line. It produces registered `mtip_o`, `msip_o` and `meip_o` level outputs for the CSR file. It is accessed through a simple single-cycle-issue, one-cycle-read-latency register port from the data bus.

## Interface
- `PRESCALE`, default 50: `clk_i` cycles per `mtime` increment; legal range 1..65535.
- `SYNC_STAGES`, default 2: flops in the `ext_irq_i` synchronizer; legal range 2..4.

- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset; one clock, asynchronous, active-high.
- `addr_i`  in  3  word offset within the register page.
- `read_enable_i`  in  1  read strobe.
- `read_data_o`  out  32  read data, registered.
- `write_enable_i`  in  1  write strobe.
- `write_data_i`  in  32  write data.
- `write_mask_i`  in  4  byte enables; bit n gates bits [8n+7:8n].
- `ext_irq_i`  in  1  asynchronous external interrupt request.
- `mtip_o`  out  1  timer interrupt pending.
- `msip_o`  out  1  software interrupt pending.
- `meip_o`  out  1  external interrupt pending.

## Operation
- Register map (word offset), with unlisted bits reading 0:
  - 0: MSIP, bit 0, R/W.
  - 1: EXTCLR, reads pending in bit 0; writing 1 to bit 0 clears pending.
  - 2: MTIMECMP[31:0].
  - 3: MTIMECMP[63:32].
  - 4: MTIME[31:0].
  - 5: MTIME[63:32].
  - 6–7: reserved; read 0, writes ignored.
- Prescaler: counter `0..PRESCALE-1`, incremented every cycle. It wraps to 0 and asserts an internal tick when it reaches `PRESCALE-1`. With `PRESCALE=1`, every cycle is a tick.
- `mtime` update:
  - On a tick, `mtime <= mtime + 1`, full 64-bit with carry from low to high.
  - `mtime` wraps from all-ones to 0.
- Write to MTIME low or high:
  - The masked bytes of the written half take the write data.
  - The other half holds its current value; there is no increment that cycle, even if a tick occurs.
  - The prescaler resets to 0.
- Writes to `mtimecmp` and MSIP apply the byte mask and take effect on the next edge.
- Timer interrupt: `mtip_o <= (mtime >= mtimecmp)`, unsigned 64-bit compare, evaluated on the pre-update register values. `mtip_o` is level-sensitive and deasserts only when software raises `mtimecmp` or writes `mtime`.
- Software interrupt: `msip_o` equals the MSIP bit register.
- External interrupt:
  - `ext_irq_i` passes through `SYNC_STAGES` flops, then one edge-detect flop.
  - A synchronized 0→1 transition sets `pending`.
  - An EXTCLR write with bit 0 = 1 clears `pending`.
  - If a set and a clear land in the same cycle, set wins.
  - `meip_o` equals `pending`.
- Reads:
  - When `read_enable_i` is high, `read_data_o <= value at addr_i` at the next edge.
  - Otherwise `read_data_o <= 0`.
  - A read and a write to the same offset in the same cycle returns the pre-write value.
  - Reading MTIME is not atomic across halves; software uses the hi/lo/hi sequence.

## Timing
- Reset values:
  - `mtime` = 0, prescaler = 0.
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
  - MSIP = 0, `pending` = 0, all synchronizer and edge flops = 0.
  - `read_data_o` = 0, `mtip_o` = 0, `msip_o` = 0, `meip_o` = 0.
- Reset asserted mid-operation clears all state immediately, independent of the clock. After release, the first tick occurs `PRESCALE` cycles after the first active edge.
- Read latency: 1 cycle. Write latency: state updated at the issuing edge, visible to a read issued the following cycle.
- `mtip_o` lags the `mtime`/`mtimecmp` state by 1 cycle.
- `msip_o` is high 1 cycle after the write edge.
- `meip_o` rises `SYNC_STAGES+2` cycles after `ext_irq_i` rises (if it is set up before an edge). It falls 1 cycle after the clearing write.
- Read and write strobes may be asserted every cycle; there is no backpressure.

## Test plan
- Reset check:
  - Stimulus: assert `reset_i` asynchronously mid-count.
  - Required: all outputs 0 with no clock; after release, MTIMECMP reads 0xFFFFFFFF for both halves, and `mtip_o` stays 0 for 1000 cycles.
- Tick rate and timer interrupt:
  - Stimulus: `PRESCALE=4`; write MTIMECMP = 5 (hi = 0).
  - Required: MTIME low reads 10 after 40 cycles from reset; `mtip_o` rises exactly 1 cycle after `mtime` becomes 5.
  - Then write MTIMECMP low = 100: `mtip_o` falls 1 cycle later.
- Carry and write priority:
  - Stimulus: write MTIME low = 0xFFFFFFFF, hi = 0; then wait.
  - Required: the next tick yields hi = 1, lo = 0.
  - Stimulus: a write to MTIME low on a tick cycle.
  - Required: the written value is held (no +1), and the next increment occurs `PRESCALE` cycles later.
- Byte masking:
  - Stimulus: MTIMECMP low = 0x11223344, then write 0xAABBCCDD with mask 4'b0101.
  - Required: MTIMECMP low reads 0x11BB33DD.
- External interrupt:
  - Stimulus: pulse `ext_irq_i` high for 1 cycle.
  - Required: `meip_o` = 1 after 4 cycles (`SYNC_STAGES=2`) and stays high when the line drops.
  - Stimulus: write EXTCLR = 1.
  - Required: `meip_o` = 0 the next cycle.
  - Stimulus: a clear coincident with a new synchronized edge.
  - Required: `meip_o` stays 1.
- Software interrupt and reserved offsets:
  - Stimulus: write MSIP = 1; then write 0.
  - Required: `msip_o` tracks the bit with 1-cycle lag.
  - Stimulus: read offset 6.
  - Required: returns 0.
  - Stimulus: read with `read_enable_i` = 0.
  - Required: `read_data_o` = 0.

Source files
------------

// File: rtl/cpu_clint.sv
// Machine timer/software/external interrupt source feeding the CSR MIP bits; 1-cycle read latency, writes land at the issuing edge.
// Strobes may be issued every cycle; there is no backpressure.
module cpu_clint #(
  parameter int PRESCALE    = 50,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [2:0]  addr_i,
  input  logic        read_enable_i,
  output logic [31:0] read_data_o,
  input  logic        write_enable_i,
  input  logic [31:0] write_data_i,
  input  logic [3:0]  write_mask_i,
  input  logic        ext_irq_i,
  output logic        mtip_o,
  output logic        msip_o,
  output logic        meip_o
);

  localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

  logic [15:0]            ps_q;
  logic [63:0]            mtime_q;
  logic [63:0]            mtimecmp_q;
  logic                   msip_q;
  logic                   pending_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d_q;
  logic                   rise_q;
  logic                   mtip_q;
  logic [31:0]            rdata_q;

  logic        tick;
  logic        wr_msip, wr_extclr, wr_cmp_lo, wr_cmp_hi, wr_mtime_lo, wr_mtime_hi;
  logic        ext_clr;
  logic [15:0] ps_nxt;
  logic [63:0] mtime_nxt;
  logic [31:0] rd_mux;

  always_comb begin
    wr_msip     = write_enable_i && (addr_i == 3'd0);
    wr_extclr   = write_enable_i && (addr_i == 3'd1);
    wr_cmp_lo   = write_enable_i && (addr_i == 3'd2);
    wr_cmp_hi   = write_enable_i && (addr_i == 3'd3);
    wr_mtime_lo = write_enable_i && (addr_i == 3'd4);
    wr_mtime_hi = write_enable_i && (addr_i == 3'd5);
    ext_clr     = wr_extclr && write_mask_i[0] && write_data_i[0];
    tick        = (ps_q == PS_MAX);
  end

  // A software write to either mtime half suppresses that cycle's increment and restarts the prescaler.
  always_comb begin
    mtime_nxt = mtime_q;
    ps_nxt    = ps_q + 16'd1;
    if (wr_mtime_lo) begin
      mtime_nxt[31:0] = merge_bytes(mtime_q[31:0], write_data_i, write_mask_i);
      ps_nxt          = 16'd0;
    end else if (wr_mtime_hi) begin
      mtime_nxt[63:32] = merge_bytes(mtime_q[63:32], write_data_i, write_mask_i);
      ps_nxt           = 16'd0;
    end else if (tick) begin
      mtime_nxt = mtime_q + 64'd1;
      ps_nxt    = 16'd0;
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (addr_i)
      3'd0:    rd_mux = {31'd0, msip_q};
      3'd1:    rd_mux = {31'd0, pending_q};
      3'd2:    rd_mux = mtimecmp_q[31:0];
      3'd3:    rd_mux = mtimecmp_q[63:32];
      3'd4:    rd_mux = mtime_q[31:0];
      3'd5:    rd_mux = mtime_q[63:32];
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ps_q       <= 16'd0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      ps_q    <= ps_nxt;
      mtime_q <= mtime_nxt;
      if (wr_cmp_lo) mtimecmp_q[31:0]  <= merge_bytes(mtimecmp_q[31:0], write_data_i, write_mask_i);
      if (wr_cmp_hi) mtimecmp_q[63:32] <= merge_bytes(mtimecmp_q[63:32], write_data_i, write_mask_i);
      if (wr_msip && write_mask_i[0]) msip_q <= write_data_i[0];
      mtip_q  <= (mtime_q >= mtimecmp_q);
      rdata_q <= read_enable_i ? rd_mux : 32'd0;
    end
  end

  // Synchronizer, then a registered rising-edge pulse; a new edge beats a coincident clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q    <= '0;
      sync_d_q  <= 1'b0;
      rise_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], ext_irq_i};
      sync_d_q <= sync_q[SYNC_STAGES-1];
      rise_q   <= sync_q[SYNC_STAGES-1] && !sync_d_q;
      if (rise_q)       pending_q <= 1'b1;
      else if (ext_clr) pending_q <= 1'b0;
    end
  end

  assign read_data_o = rdata_q;
  assign mtip_o      = mtip_q;
  assign msip_o      = msip_q;
  assign meip_o      = pending_q;

endmodule

// File: tb/tb_cpu_clint.sv
// Bench for cpu_clint: vector table, directed corner sequences and a random run against a time-based model.
module tb_cpu_clint;
  localparam int PS = 4;
  localparam int SS = 2;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [2:0]  addr_i;
  logic        read_enable_i;
  logic [31:0] read_data_o;
  logic        write_enable_i;
  logic [31:0] write_data_i;
  logic [3:0]  write_mask_i;
  logic        ext_irq_i;
  logic        mtip_o, msip_o, meip_o;

  cpu_clint #(.PRESCALE(PS), .SYNC_STAGES(SS)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .addr_i(addr_i),
    .read_enable_i(read_enable_i), .read_data_o(read_data_o),
    .write_enable_i(write_enable_i), .write_data_i(write_data_i),
    .write_mask_i(write_mask_i), .ext_irq_i(ext_irq_i),
    .mtip_o(mtip_o), .msip_o(msip_o), .meip_o(meip_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model: mtime is an anchor value plus whole prescale periods elapsed since the anchor edge.
  logic [63:0]     m_base;
  longint unsigned m_n;
  logic [63:0]     m_cmp;
  bit              m_msip, m_pend, m_mtip;
  logic [31:0]     m_rd;
  bit              hist[$];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_mtime();
    return m_base + 64'(m_n / longint'(PS));
  endfunction

  function automatic logic [31:0] m_val(input logic [2:0] a);
    logic [63:0] mt;
    mt = m_mtime();
    case (a)
      3'd0:    return {31'd0, m_msip};
      3'd1:    return {31'd0, m_pend};
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return mt[31:0];
      3'd5:    return mt[63:32];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_base = 64'd0; m_n = 0; m_cmp = '1;
    m_msip = 0; m_pend = 0; m_mtip = 0; m_rd = 32'd0;
    hist = {};
    repeat (SS + 3) hist.push_back(1'b0);
  endtask

  task automatic model_edge(input bit re, input bit we, input logic [2:0] a,
                            input logic [31:0] wd, input logic [3:0] m, input bit ext);
    logic [63:0] mt;
    bit rise, clr;
    mt     = m_mtime();
    m_rd   = re ? m_val(a) : 32'd0;
    m_mtip = (mt >= m_cmp);
    hist.push_front(ext);
    void'(hist.pop_back());
    // hist[i] is the line as sampled i edges ago; the rise shows up SS+2 edges later.
    rise   = hist[SS+1] && !hist[SS+2];
    clr    = we && (a == 3'd1) && m[0] && wd[0];
    m_pend = rise || (m_pend && !clr);
    if (we && a == 3'd0 && m[0]) m_msip = wd[0];
    if (we && a == 3'd2) m_cmp[31:0]  = merge(m_cmp[31:0], wd, m);
    if (we && a == 3'd3) m_cmp[63:32] = merge(m_cmp[63:32], wd, m);
    if (we && (a == 3'd4 || a == 3'd5)) begin
      if (a == 3'd4) m_base = {mt[63:32], merge(mt[31:0], wd, m)};
      else           m_base = {merge(mt[63:32], wd, m), mt[31:0]};
      m_n = 0;
    end else begin
      m_n++;
    end
  endtask

  task automatic step(input bit re, input bit we, input logic [2:0] a,
                      input logic [31:0] wd, input logic [3:0] m);
    read_enable_i  = re;
    write_enable_i = we;
    addr_i         = a;
    write_data_i   = wd;
    write_mask_i   = m;
    @(posedge clk_i);
    model_edge(re, we, a, wd, m, ext_irq_i);
    #1;
    check("model_rd",   read_data_o, m_rd);
    check("model_mtip", mtip_o, m_mtip);
    check("model_msip", msip_o, m_msip);
    check("model_meip", meip_o, m_pend);
  endtask

  task automatic idle();
    step(0, 0, 3'd0, 32'd0, 4'h0);
  endtask

  task automatic do_reset();
    read_enable_i = 0; write_enable_i = 0; ext_irq_i = 0;
    #2 reset_i = 1'b1;
    #1;
    check("rst_rd",   read_data_o, 0);
    check("rst_mtip", mtip_o, 0);
    check("rst_msip", msip_o, 0);
    check("rst_meip", meip_o, 0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
  endtask

  typedef struct {
    bit          we;
    bit          re;
    logic [2:0]  a;
    logic [31:0] wd;
    logic [3:0]  m;
    logic [31:0] exp_rd;
    bit          exp_msip;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[17];
    int   first_mtip;
    bit   mtip_seen;

    tbl[0]  = '{1, 0, 3'd2, 32'h11223344, 4'hF, 32'h0,        0};
    tbl[1]  = '{1, 1, 3'd2, 32'hAABBCCDD, 4'h5, 32'h11223344, 0};
    tbl[2]  = '{0, 1, 3'd2, 32'h0,        4'h0, 32'h11BB33DD, 0};
    tbl[3]  = '{0, 1, 3'd3, 32'h0,        4'h0, 32'hFFFFFFFF, 0};
    tbl[4]  = '{1, 0, 3'd3, 32'h000000A5, 4'h1, 32'h0,        0};
    tbl[5]  = '{0, 1, 3'd3, 32'h0,        4'h0, 32'hFFFFFFA5, 0};
    tbl[6]  = '{1, 1, 3'd0, 32'h1,        4'hF, 32'h0,        1};
    tbl[7]  = '{0, 1, 3'd0, 32'h0,        4'h0, 32'h1,        1};
    tbl[8]  = '{0, 1, 3'd6, 32'h0,        4'h0, 32'h0,        1};
    tbl[9]  = '{1, 0, 3'd6, 32'hDEADBEEF, 4'hF, 32'h0,        1};
    tbl[10] = '{0, 1, 3'd6, 32'h0,        4'h0, 32'h0,        1};
    tbl[11] = '{0, 1, 3'd7, 32'h0,        4'h0, 32'h0,        1};
    tbl[12] = '{0, 0, 3'd2, 32'h0,        4'h0, 32'h0,        1};
    tbl[13] = '{1, 1, 3'd0, 32'hFFFFFFFE, 4'hF, 32'h1,        0};
    tbl[14] = '{0, 1, 3'd1, 32'h0,        4'h0, 32'h0,        0};
    tbl[15] = '{1, 0, 3'd0, 32'h1,        4'hE, 32'h0,        0};
    tbl[16] = '{0, 1, 3'd0, 32'h0,        4'h0, 32'h0,        0};

    reset_i = 1'b1; read_enable_i = 0; write_enable_i = 0; addr_i = 0;
    write_data_i = 0; write_mask_i = 0; ext_irq_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("init_rd",   read_data_o, 0);
    check("init_mtip", mtip_o, 0);
    reset_i = 1'b0;

    // Tick rate and timer interrupt: edges counted from reset release.
    first_mtip = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 1)      step(0, 1, 3'd2, 32'd5, 4'hF);
      else if (k == 2) step(0, 1, 3'd3, 32'd0, 4'hF);
      else             idle();
      if (mtip_o && first_mtip == 0) first_mtip = k;
    end
    step(1, 0, 3'd4, 32'd0, 4'h0);
    check("mtime_lo_at_40", read_data_o, 32'd10);
    check("mtip_rise_edge", first_mtip, 21);
    step(0, 1, 3'd2, 32'd100, 4'hF);
    check("mtip_before_fall", mtip_o, 1);
    idle();
    check("mtip_fall", mtip_o, 0);

    // Carry into the high half, then a low write landing on a tick edge.
    step(0, 1, 3'd4, 32'hFFFFFFFF, 4'hF);
    step(0, 1, 3'd5, 32'h0, 4'hF);
    for (int i = 1; i <= 13; i++) begin
      if (i == 5)      step(1, 0, 3'd5, 0, 0);
      else if (i == 6) step(1, 0, 3'd4, 0, 0);
      else if (i == 8) step(0, 1, 3'd4, 32'h12345678, 4'hF);
      else if (i >= 9) step(1, 0, 3'd4, 0, 0);
      else             idle();
      if (i == 5)  check("carry_hi", read_data_o, 32'd1);
      if (i == 6)  check("carry_lo", read_data_o, 32'd0);
      if (i >= 9 && i <= 12) check("tick_write_held", read_data_o, 32'h12345678);
      if (i == 13) check("tick_after_write", read_data_o, 32'h12345679);
    end

    // Drive every output high, then reset asynchronously mid-cycle.
    step(0, 1, 3'd0, 32'h1, 4'hF);
    ext_irq_i = 1;
    idle();
    ext_irq_i = 0;
    repeat (4) idle();
    step(1, 0, 3'd4, 0, 0);
    check("pre_rst_mtip", mtip_o, 1);
    check("pre_rst_msip", msip_o, 1);
    check("pre_rst_meip", meip_o, 1);
    do_reset();
    step(1, 0, 3'd3, 0, 0);
    check("rst_cmp_hi", read_data_o, 32'hFFFFFFFF);
    step(1, 0, 3'd2, 0, 0);
    check("rst_cmp_lo", read_data_o, 32'hFFFFFFFF);
    mtip_seen = 0;
    repeat (1000) begin
      idle();
      if (mtip_o) mtip_seen = 1;
    end
    check("mtip_quiet_1000", mtip_seen, 0);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].re, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].m);
      check($sformatf("tbl%0d_rd", i), read_data_o, tbl[i].exp_rd);
      check($sformatf("tbl%0d_msip", i), msip_o, tbl[i].exp_msip);
    end

    // External interrupt: one-cycle pulse, clear, then clear racing a new edge.
    ext_irq_i = 1;
    for (int i = 1; i <= 8; i++) begin
      idle();
      ext_irq_i = 0;
      check($sformatf("meip_pulse_%0d", i), meip_o, (i >= 4));
    end
    step(0, 1, 3'd1, 32'h1, 4'hF);
    check("meip_clear", meip_o, 0);
    ext_irq_i = 1;
    for (int i = 1; i <= 6; i++) begin
      if (i == 4 || i == 6) step(0, 1, 3'd1, 32'h1, 4'hF);
      else                  idle();
      if (i == 4) check("meip_set_wins", meip_o, 1);
      if (i == 5) check("meip_hold", meip_o, 1);
      if (i == 6) check("meip_level_no_reset", meip_o, 0);
    end
    ext_irq_i = 0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] wd;
      wd = $urandom;
      if ($urandom_range(0, 1) == 1) wd = 32'($urandom_range(0, 64));
      if ($urandom_range(0, 9) == 0) ext_irq_i = ~ext_irq_i;
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           3'($urandom_range(0, 7)), wd, 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
